// File: rtl/cpu_wb_master_if.sv
// Classic single-beat Wishbone connection between the CPU bridge (master) and a bus slave.
interface cpu_wb_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                cyc;
   logic                stb;
   logic                we;
   logic [DATA_W/8-1:0] sel;
   logic [ADDR_W-1:0]   adr;
   logic [DATA_W-1:0]   dat_w;
   logic [DATA_W-1:0]   dat_r;
   logic                ack;
   logic                err;

   modport master (
      output cyc, stb, we, sel, adr, dat_w,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_w,
      output dat_r, ack, err
   );
endinterface

// File: rtl/cpu_wb_master.sv
// CPU memory-port to Wishbone single-beat bridge: one bus cycle per CPU request, one-cycle ready strobe.
// Optional bus timeout abort is compiled in when WB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no cycle on the bus; a CPU request latches addr/data/we and raises cyc/stb
// BUS   | cyc/stb held with the latched request; waiting for ack, err (or timeout)
// RESP  | cpu_ready_o high for this single cycle; returns to IDLE regardless of request
module cpu_wb_master #(
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_stb_i,
   input  logic                 cpu_we_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [DATA_W-1:0]    cpu_dat_i,
   output logic [DATA_W-1:0]    cpu_dat_o,
   output logic                 cpu_ready_o,
   output logic                 bus_err_o,
   cpu_wb_master_if.master      wb
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic   to_hit;
   logic   bus_abort;

`ifdef WB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt;

   // Counter equals the number of completed BUS cycles, so a hit means this is BUS cycle TIMEOUT.
   assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`else
   wire unused_timeout_cfg = (TIMEOUT >= 1);

   assign to_hit = 1'b0;
`endif

   // A slave response in the same cycle as the timeout wins over the timeout.
   assign bus_abort = wb.err || (to_hit && !wb.ack);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wb.cyc      <= 1'b0;
         wb.stb      <= 1'b0;
         wb.we       <= 1'b0;
         wb.sel      <= '0;
         wb.adr      <= '0;
         wb.dat_w    <= '0;
         cpu_dat_o   <= '0;
         cpu_ready_o <= 1'b0;
         bus_err_o   <= 1'b0;
`ifdef WB_TIMEOUT_EN
         to_cnt      <= '0;
`endif
      end else begin
         cpu_ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_stb_i) begin
                  wb.adr   <= cpu_addr_i;
                  wb.dat_w <= cpu_dat_i;
                  wb.we    <= cpu_we_i;
                  wb.cyc   <= 1'b1;
                  wb.stb   <= 1'b1;
                  wb.sel   <= '1;
`ifdef WB_TIMEOUT_EN
                  to_cnt   <= '0;
`endif
                  state    <= BUS;
               end
            end
            BUS: begin
               if (bus_abort) begin
                  if (!wb.we) cpu_dat_o <= '0;
                  bus_err_o   <= 1'b1;
                  wb.cyc      <= 1'b0;
                  wb.stb      <= 1'b0;
                  wb.sel      <= '0;
                  cpu_ready_o <= 1'b1;
                  state       <= RESP;
               end else if (wb.ack) begin
                  if (!wb.we) cpu_dat_o <= wb.dat_r;
                  wb.cyc      <= 1'b0;
                  wb.stb      <= 1'b0;
                  wb.sel      <= '0;
                  cpu_ready_o <= 1'b1;
                  state       <= RESP;
               end
`ifdef WB_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
